imem_port_arbiter: RTL and testbench

// - Shares the single instruction-memory port between the fetch stage (read-only) and a program loader (read/write).
// - Sits between fetch and instruction memory:
//   - muxes the address, write enable and write data to memory;
//   - returns read data to both requesters;
//   - drives fetch_stall_c into the fetch stall OR when fetch is not the owner.
// - Bounded loader bursts guarantee forward progress for fetch.

---
 rtl/imem_port_arbiter.sv | 105 ++++++++++
 tb/tb_imem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch (read-only) and a program loader (read/write).
// Optional IMEM_BOOT_HOLD_EN: reset enters BOOT and fetch is held until the loader raises ld_boot_done_c.
module imem_port_arbiter #(
  parameter int ADDRESS_SIZE   = 32,
  parameter int DATA_SIZE      = 32,
  parameter int MAX_LOAD_BURST = 8,
  localparam int CNT_W         = $clog2(MAX_LOAD_BURST + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    fetch_req_c,
  input  logic [ADDRESS_SIZE-1:0] fetch_addr,
  output logic [DATA_SIZE-1:0]    fetch_data,
  output logic                    fetch_stall_c,
  input  logic                    ld_req_c,
  input  logic                    ld_we,
  input  logic [ADDRESS_SIZE-1:0] ld_addr,
  input  logic [DATA_SIZE-1:0]    ld_wdata,
  input  logic                    ld_boot_done_c,
  output logic                    ld_gnt_c,
  output logic [DATA_SIZE-1:0]    ld_rdata,
  input  logic [DATA_SIZE-1:0]    im_read_data,
  output logic [ADDRESS_SIZE-1:0] im_read_address,
  output logic                    im_write_enable,
  output logic [DATA_SIZE-1:0]    im_write_data,
  output logic [1:0]              dbg_state_o,
  output logic [CNT_W-1:0]        dbg_burst_cnt_o
);

  // Handshake: the loader holds ld_req_c and its operands until ld_gnt_c; a granted access completes
  // in that same cycle (read data is combinational). Fetch holds its PC while fetch_stall_c is high.

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BOOT  = 2'd2
  } state_e;

`ifdef IMEM_BOOT_HOLD_EN
  localparam state_e RESET_STATE = ST_BOOT;
`else
  localparam state_e RESET_STATE = ST_FETCH;
  logic unused_boot_done;
  assign unused_boot_done = ld_boot_done_c;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOAD_BURST);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             loader_sel;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Only grants made while fetch is waiting count toward the forced yield.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cnt_inc     = burst_cnt_q + CNT_W'(1);
    case (state_q)
      ST_FETCH: begin
        if (ld_req_c) begin
          state_d     = ST_LOAD;
          burst_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (!ld_req_c) begin
          state_d = ST_FETCH;
        end else if (fetch_req_c) begin
          burst_cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = ST_FETCH;
        end
      end
`ifdef IMEM_BOOT_HOLD_EN
      ST_BOOT: begin
        if (ld_boot_done_c) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  assign loader_sel      = (state_q != ST_FETCH);
  assign im_read_address = loader_sel ? ld_addr : fetch_addr;
  assign ld_gnt_c        = reset_n & loader_sel & ld_req_c;
  assign fetch_stall_c   = loader_sel & fetch_req_c;
  assign im_write_enable = ld_gnt_c & ld_we;
  assign im_write_data   = ld_wdata;
  assign fetch_data      = im_read_data;
  assign ld_rdata        = im_read_data;

  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: per-cycle scoreboard of port decode plus directed burst/reset/boot checks.
module tb_imem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAXB  = 8;
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam int OBS_W = 3 + AW;

`ifdef IMEM_BOOT_HOLD_EN
  localparam logic [1:0] RST_ST = 2'd2;
`else
  localparam logic [1:0] RST_ST = 2'd0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             fetch_req_c = 1'b0;
  logic [AW-1:0]    fetch_addr = '0;
  logic [DW-1:0]    fetch_data;
  logic             fetch_stall_c;
  logic             ld_req_c = 1'b0;
  logic             ld_we = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [DW-1:0]    ld_wdata = '0;
  logic             ld_boot_done_c = 1'b0;
  logic             ld_gnt_c;
  logic [DW-1:0]    ld_rdata;
  logic [DW-1:0]    im_read_data;
  logic [AW-1:0]    im_read_address;
  logic             im_write_enable;
  logic [DW-1:0]    im_write_data;
  logic [1:0]       dbg_state_o;
  logic [CNT_W-1:0] dbg_burst_cnt_o;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  imem_port_arbiter #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MAX_LOAD_BURST(MAXB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req_c(fetch_req_c), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_stall_c(fetch_stall_c),
    .ld_req_c(ld_req_c), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_boot_done_c(ld_boot_done_c), .ld_gnt_c(ld_gnt_c), .ld_rdata(ld_rdata),
    .im_read_data(im_read_data), .im_read_address(im_read_address),
    .im_write_enable(im_write_enable), .im_write_data(im_write_data),
    .dbg_state_o(dbg_state_o), .dbg_burst_cnt_o(dbg_burst_cnt_o)
  );

  // Instruction memory: combinational read, written once per cycle when strobed.
  logic [DW-1:0] mem [256];
  assign im_read_data = mem[im_read_address[9:2]];

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // ---------------- scoreboard ----------------
  int               n_vec = 0;
  int               n_miss = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic [1:0]       m_state;
  int               m_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic freq, input logic [AW-1:0] faddr,
                       input logic lreq, input logic lwe, input logic [AW-1:0] laddr,
                       input logic [DW-1:0] lwd, input logic bdone);
    logic             sel, gnt;
    logic [OBS_W-1:0] obs;
    @(posedge clock);
    #1;
    reset_n = rst; fetch_req_c = freq; fetch_addr = faddr; ld_req_c = lreq;
    ld_we = lwe; ld_addr = laddr; ld_wdata = lwd; ld_boot_done_c = bdone;
    sel = (m_state != 2'd0);
    gnt = rst & sel & lreq;
    exp_q.push_back({gnt, sel & freq, gnt & lwe, sel ? laddr : faddr});
    #2;
    obs = {ld_gnt_c, fetch_stall_c, im_write_enable, im_read_address};
    check_val("port", obs, exp_q.pop_front());
    check_val("state", dbg_state_o, m_state);
    check_val("wdata", im_write_data, lwd);
    if (im_write_enable === 1'b1) mem[im_read_address[9:2]] = im_write_data;
    if (!rst) begin
      m_state = RST_ST;
      m_cnt   = 0;
    end else begin
      case (m_state)
        2'd0: if (lreq) begin m_state = 2'd1; m_cnt = 0; end
        2'd1: begin
          if (!lreq) m_state = 2'd0;
          else if (freq) begin
            m_cnt++;
            if (m_cnt == MAXB) m_state = 2'd0;
          end
        end
        default: if (bdone) m_state = 2'd0;
      endcase
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int run, max_run;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    m_state = RST_ST;
    m_cnt   = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_state", dbg_state_o, RST_ST);
    check_val("rst_cnt", dbg_burst_cnt_o, 0);
    check_val("rst_gnt", ld_gnt_c, 0);
    check_val("rst_we", im_write_enable, 0);
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1111_1111, 1'b0);

`ifdef IMEM_BOOT_HOLD_EN
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hB007_0000 + 32'(i), 1'b0);
      check_val("boot_stall", fetch_stall_c, 1);
      check_val("boot_gnt", ld_gnt_c, 1);
    end
    cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b1);
    check_val("boot_done_stall", fetch_stall_c, 1);
    cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 1'b0);
    check_val("boot_release", fetch_stall_c, 0);
`endif

    // fetch only: address follows PC each cycle
    for (int a = 0; a <= 8; a += 4) begin
      cycle(1'b1, 1'b1, 32'(a), 1'b0, 1'b0, 32'h40, '0, 1'b0);
      check_val("fetch_data", fetch_data, init_word(a >> 2));
      check_val("fetch_stall", fetch_stall_c, 0);
    end

    // single loader write, grant one cycle after the request
    cycle(1'b1, 1'b0, 32'hC, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    check_val("wr_lat", ld_gnt_c, 0);
    cycle(1'b1, 1'b0, 32'hC, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    check_val("wr_gnt", ld_gnt_c, 1);
    check_val("wr_we", im_write_enable, 1);
    check_val("wr_addr", im_read_address, 32'h40);
    cycle(1'b1, 1'b0, 32'hC, 1'b0, 1'b0, 32'h40, '0, 1'b0);
    idle();
    check_val("wr_back", dbg_state_o, 0);

    // loader read-back while fetch waits
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, '0, 1'b0);
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, '0, 1'b0);
    check_val("rd_data", ld_rdata, 32'hDEAD_BEEF);
    check_val("rd_stall", fetch_stall_c, 1);
    check_val("rd_gnt", ld_gnt_c, 1);
    cycle(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h40, '0, 1'b0);
    idle();

    // contention: 1 fetch cycle then MAXB loader grants, repeating
    run = 0;
    max_run = 0;
    for (int i = 0; i < 4 * (MAXB + 1); i++) begin
      cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h44, '0, 1'b0);
      check_val("burst_stall", fetch_stall_c, (i % (MAXB + 1)) != 0);
      if (fetch_stall_c === 1'b1) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    check_val("burst_max_run", max_run, MAXB);
    idle();

    // lone loader is never forced to yield
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h48, '0, 1'b0);
      check_val("lone_gnt", ld_gnt_c, i != 0);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h48, '0, 1'b0);
    idle();

    // reset asserted during the 3rd grant of a write burst
    for (int i = 0; i < 4; i++) begin
      cycle((i == 3) ? 1'b0 : 1'b1, 1'b1, 32'h30, 1'b1, 1'b1, 32'h7C + 32'(4 * i),
            32'hDEAD_0000 + 32'(i), 1'b0);
    end
    check_val("rst_burst_we", im_write_enable, 0);
    check_val("rst_burst_gnt", ld_gnt_c, 0);
    cycle(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, '0, '0, 1'b0);
    check_val("rst_burst_state", dbg_state_o, RST_ST);
    check_val("rst_burst_cnt", dbg_burst_cnt_o, 0);
    check_val("rst_burst_mem2", mem[8'h21], 32'hDEAD_0002);
    check_val("rst_burst_mem3", mem[8'h22], init_word(8'h22));
`ifdef IMEM_BOOT_HOLD_EN
    cycle(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, '0, '0, 1'b1);
`endif
    cycle(1'b1, 1'b1, 32'h34, 1'b0, 1'b0, '0, '0, 1'b0);
    check_val("final_fetch", fetch_data, init_word(8'h0D));
    check_val("final_stall", fetch_stall_c, 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
